ysyx_22040237_lsu: RTL and testbench
====================================

// Module: ysyx_22040237_lsu
// PURPOSE
//  Load/store unit: consumes EXU's {ls_info_bus, alu_res (address), rs2_store} and runs one access per request
//  on a 64-bit req/gnt/rvalid memory port. Aligns store data and byte mask; extracts and extends load data.
//  Sends rd writeback on a one-cycle valid pulse. Non-LS requests pass through with alu_res as wb data.
//  Sits between EXU and the writeback/regfile stage.
// PARAMETERS
//  XLEN       64  datapath/address width (only 64 supported)
//  CHK_ALIGN  1   1: misaligned access raises err_o, no memory request; 0: no alignment check
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous reset, active-low
//  in_valid_i    in   1     EXU request valid
//  in_ready_o    out  1     LSU can accept (high only in IDLE)
//  ls_info_i     in   7     {dw,word,db,byte,usign,store,load}
//  addr_i        in   XLEN  effective address (EXU alu_res)
//  st_data_i     in   XLEN  store data (rs2), LSB-aligned
//  rd_wr_en_i    in   1     rd write enable from EXU
//  rd_idx_i      in   5     rd index from EXU
//  mem_req_o     out  1     memory request, held until granted
//  mem_we_o      out  1     1 = write
//  mem_addr_o    out  XLEN  {addr[63:3],3'b0}
//  mem_wdata_o   out  XLEN  store data shifted to byte lane addr[2:0]
//  mem_wmask_o   out  8     byte strobes
//  mem_gnt_i     in   1     request accepted (write = complete)
//  mem_rvalid_i  in   1     read data valid
//  mem_rdata_i   in   XLEN  read data, full doubleword
//  wb_valid_o    out  1     one-cycle writeback pulse
//  wb_rd_wr_en_o out  1     rd write enable. Forced 0 for stores and errors.
//  wb_rd_idx_o   out  5     rd index
//  wb_data_o     out  XLEN  load result or pass-through alu_res
//  err_o         out  1     misaligned access, valid with wb_valid_o
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except in_ready_o=1.
//  FSM: IDLE, REQ, WAIT, RESP. All request fields are registered on accept (in_valid_i & in_ready_o).
//  IDLE: on accept:
//   - load or store, aligned -> REQ
//   - otherwise (non-LS, or misaligned) -> RESP
//  REQ: mem_req_o=1. Address, we, wdata and wmask stay stable until gnt.
//   - gnt & store -> RESP
//   - gnt & load & rvalid in the same cycle -> capture data, RESP
//   - gnt & load -> WAIT
//  WAIT: on rvalid -> capture data, RESP. rvalid in any other state is ignored.
//  RESP: wb_valid_o=1 for exactly one cycle, then IDLE. Earliest next accept is the cycle after RESP.
//  Latency, accept edge to wb_valid_o:
//   - non-LS: 1 cycle
//   - store with immediate gnt: 2 cycles
//   - load with gnt+rvalid together: 2 cycles
//  Size comes from the one-hot {dw,word,db,byte} = 8/4/2/1 bytes. If no size bit is set, treat as byte.
//  Store: wmask = ((1<<size)-1) << addr[2:0]. wdata = st_data << (8*addr[2:0]).
//  Load: shift rdata >> (8*addr[2:0]), keep `size` bytes. usign=1 zero-extends, else sign-extends from the top kept bit.
//  Misaligned (CHK_ALIGN=1): db with addr[0]; word with addr[1:0]!=0; dw with addr[2:0]!=0.
//   -> no mem_req_o, err_o=1, wb_rd_wr_en_o=0.
//  Non-LS request: wb_data_o=addr_i, wb_rd_wr_en_o=rd_wr_en_i.
//  load=store=1 together is illegal. Store wins.
//  wb_rd_wr_en_o=0 for stores. For loads, wb_rd_wr_en_o = rd_wr_en_i && rd_idx_i!=0.
//  Reset mid-operation drops the access immediately: no wb pulse, mem_req_o deasserts asynchronously.
// TESTING
//  1. Non-LS: addr_i=0x1234, rd_idx=5, rd_wr_en=1
//     -> next cycle wb_valid_o=1, wb_data_o=0x1234, rd 5, no mem_req_o.
//  2. lb, addr=0x8000_0003, rdata=0x0000_0000_8000_0000, gnt+rvalid together
//     -> wb_data_o=0xFFFF_FFFF_FFFF_FF80. Same with usign (lbu) -> 0x80.
//  3. sh, addr=0x...6, st_data=0xBEEF, gnt after 3 cycles
//     -> mem_wmask_o=0xC0, wdata[63:48]=0xBEEF, mem_req_o held 4 cycles, wb_rd_wr_en_o=0.
//  4. lw, addr=0x...2
//     -> no mem_req_o, next cycle wb_valid_o=1, err_o=1, wb_rd_wr_en_o=0.
//  5. ld with gnt, then rvalid 5 cycles later, rdata=0x0123_4567_89AB_CDEF
//     -> in_ready_o low throughout, wb_data_o=0x0123_4567_89AB_CDEF. A stray rvalid while in REQ is ignored.
//  6. Assert rst low during WAIT
//     -> mem_req_o=0, in_ready_o=1, no wb_valid_o. First request after release behaves normally.

Source files
------------

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit between EXU and writeback. It issues one access per request on a
// 64-bit req/gnt/rvalid port and returns one writeback pulse per request.
module ysyx_22040237_lsu #(
  parameter int XLEN      = 64,
  parameter bit CHK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [6:0]      ls_info_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wmask_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  output logic            wb_rd_wr_en_o,
  output logic [4:0]      wb_rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] size_lg;
  logic       req_store;
  logic       req_load;
  logic       req_ls;
  logic       misalign;

  logic       ld_usign_p0;
  logic [1:0] ld_size_p0;
  logic [2:0] ld_off_p0;
  logic       ld_wr_en_p0;
  logic       st_p0;

  function automatic logic [7:0] lane_mask(input logic [1:0] lg, input logic [2:0] off);
    logic [15:0] m;
    case (lg)
      2'd0:    m = 16'h0001;
      2'd1:    m = 16'h0003;
      2'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << off;
    return m[7:0];
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0] lg,
                                                  input logic [2:0] off,
                                                  input logic usign);
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (lg)
      2'd0:    return usign ? {{(XLEN-8){1'b0}}, sh[7:0]}   : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'd1:    return usign ? {{(XLEN-16){1'b0}}, sh[15:0]} : {{(XLEN-16){sh[15]}}, sh[15:0]};
      2'd2:    return usign ? {{(XLEN-32){1'b0}}, sh[31:0]} : {{(XLEN-32){sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // Request decode: size from the one-hot width bits, byte when none is set; store beats load.
  always_comb begin
    casez (ls_info_i[6:3])
      4'b1???: size_lg = 2'd3;
      4'b01??: size_lg = 2'd2;
      4'b001?: size_lg = 2'd1;
      4'b0001: size_lg = 2'd0;
      default: size_lg = 2'd0;
    endcase
    req_store = ls_info_i[1];
    req_load  = ls_info_i[0] & ~ls_info_i[1];
    req_ls    = req_store | req_load;
    case (size_lg)
      2'd1:    misalign = addr_i[0];
      2'd2:    misalign = |addr_i[1:0];
      2'd3:    misalign = |addr_i[2:0];
      default: misalign = 1'b0;
    endcase
    misalign = misalign & req_ls & CHK_ALIGN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      in_ready_o    <= 1'b1;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_wmask_o   <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_wr_en_o <= 1'b0;
      wb_rd_idx_o   <= '0;
      wb_data_o     <= '0;
      err_o         <= 1'b0;
      ld_usign_p0   <= 1'b0;
      ld_size_p0    <= '0;
      ld_off_p0     <= '0;
      ld_wr_en_p0   <= 1'b0;
      st_p0         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            in_ready_o  <= 1'b0;
            wb_rd_idx_o <= rd_idx_i;
            ld_usign_p0 <= ls_info_i[2];
            ld_size_p0  <= size_lg;
            ld_off_p0   <= addr_i[2:0];
            ld_wr_en_p0 <= req_load & rd_wr_en_i & (rd_idx_i != 5'd0);
            st_p0       <= req_store;
            if (req_ls && !misalign) begin
              state       <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_store;
              mem_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
              mem_wdata_o <= st_data_i << {addr_i[2:0], 3'b000};
              mem_wmask_o <= lane_mask(size_lg, addr_i[2:0]);
            end else begin
              // Non-LS passes alu_res through; a misaligned access reports an error instead.
              state         <= RESP;
              wb_valid_o    <= 1'b1;
              err_o         <= misalign;
              wb_rd_wr_en_o <= misalign ? 1'b0 : rd_wr_en_i;
              wb_data_o     <= misalign ? '0 : addr_i;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (st_p0) begin
              state         <= RESP;
              wb_valid_o    <= 1'b1;
              wb_rd_wr_en_o <= 1'b0;
              wb_data_o     <= '0;
            end else if (mem_rvalid_i) begin
              state         <= RESP;
              wb_valid_o    <= 1'b1;
              wb_rd_wr_en_o <= ld_wr_en_p0;
              wb_data_o     <= load_extend(mem_rdata_i, ld_size_p0, ld_off_p0, ld_usign_p0);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state         <= RESP;
            wb_valid_o    <= 1'b1;
            wb_rd_wr_en_o <= ld_wr_en_p0;
            wb_data_o     <= load_extend(mem_rdata_i, ld_size_p0, ld_off_p0, ld_usign_p0);
          end
        end
        default: begin
          state      <= IDLE;
          wb_valid_o <= 1'b0;
          err_o      <= 1'b0;
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Scoreboard bench for the LSU: stimulus pushes expected memory requests and writebacks,
// a memory responder and a writeback monitor pop and compare them.
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [6:0]  ls_info_i = '0;
  logic [63:0] addr_i = '0;
  logic [63:0] st_data_i = '0;
  logic        rd_wr_en_i = 1'b0;
  logic [4:0]  rd_idx_i = '0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_rd_wr_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        err_o;

  always #5 clk = ~clk;

  ysyx_22040237_lsu #(.XLEN(64), .CHK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .ls_info_i(ls_info_i),
    .addr_i(addr_i), .st_data_i(st_data_i), .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_wr_en_o(wb_rd_wr_en_o), .wb_rd_idx_o(wb_rd_idx_o),
    .wb_data_o(wb_data_o), .err_o(err_o)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        en;
    logic        err;
    logic        chk_data;
  } wb_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] rdata;
  } mem_t;

  wb_t  wb_q[$];
  mem_t mem_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit auto_mem = 1'b1;
  int f_gdly = -1;
  int f_both = -1;
  int f_rdly = -1;
  int f_stray = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick n bytes starting at byte off, then zero- or sign-extend.
  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input int n,
                                           input int off, input bit usign);
    logic [63:0] v, m;
    v = rdata >> (8 * off);
    m = (64'd1 << (8 * n)) - 64'd1;
    if (n == 8) m = '1;
    v = v & m;
    if (!usign && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic issue(input logic [6:0] info, input logic [63:0] addr, input logic [63:0] st,
                       input logic en, input logic [4:0] idx, input logic [63:0] rdata,
                       input bit push);
    int  n, off, t;
    bit  ld, stb, mis;
    logic [15:0] m16;
    n   = info[6] ? 8 : info[5] ? 4 : info[4] ? 2 : 1;
    off = int'(addr[2:0]);
    stb = info[1];
    ld  = info[0] && !info[1];
    mis = (stb || ld) && ((n == 2 && off % 2 != 0) || (n == 4 && off % 4 != 0) ||
                          (n == 8 && off != 0));
    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_o) chk("ready_timeout", 64'(in_ready_o), 64'd1);
    if (push) begin
      if (!(stb || ld))
        wb_q.push_back('{data: addr, idx: idx, en: en, err: 1'b0, chk_data: 1'b1});
      else if (mis)
        wb_q.push_back('{data: 64'd0, idx: idx, en: 1'b0, err: 1'b1, chk_data: 1'b0});
      else if (stb) begin
        m16 = 16'((1 << n) - 1) << off;
        mem_q.push_back('{we: 1'b1, addr: addr & ~64'd7, wdata: st << (8 * off),
                          mask: m16[7:0], rdata: 64'd0});
        wb_q.push_back('{data: 64'd0, idx: idx, en: 1'b0, err: 1'b0, chk_data: 1'b0});
      end else begin
        mem_q.push_back('{we: 1'b0, addr: addr & ~64'd7, wdata: 64'd0, mask: 8'd0, rdata: rdata});
        wb_q.push_back('{data: exp_load(rdata, n, off, info[2]), idx: idx,
                         en: en && (idx != 5'd0), err: 1'b0, chk_data: 1'b1});
      end
    end
    in_valid_i = 1'b1;
    ls_info_i  = info;
    addr_i     = addr;
    st_data_i  = st;
    rd_wr_en_i = en;
    rd_idx_i   = idx;
    @(negedge clk);
    in_valid_i = 1'b0;
    ls_info_i  = 7'($urandom);
    addr_i     = {$urandom, $urandom};
  endtask

  task automatic serve();
    mem_t e;
    int   gd, rd;
    bit   both;
    if (mem_q.size() == 0) begin
      chk("unexpected_mem_req", 64'd1, 64'd0);
      e = '{we: mem_we_o, addr: mem_addr_o, wdata: 64'd0, mask: 8'd0, rdata: 64'd0};
    end else begin
      e = mem_q.pop_front();
      chk("mem_we", 64'(mem_we_o), 64'(e.we));
      chk("mem_addr", mem_addr_o, e.addr);
      if (e.we) begin
        chk("mem_wdata", mem_wdata_o, e.wdata);
        chk("mem_wmask", 64'(mem_wmask_o), 64'(e.mask));
      end
    end
    gd = (f_gdly >= 0) ? f_gdly : int'($urandom_range(0, 3));
    for (int i = 0; i < gd; i++) begin
      mem_rvalid_i = (f_stray > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      mem_rdata_i  = {$urandom, $urandom};
      @(negedge clk);
      chk("req_held", 64'(mem_req_o), 64'd1);
      chk("req_addr_stable", mem_addr_o, e.addr);
      chk("ready_low_req", 64'(in_ready_o), 64'd0);
    end
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    both = e.we ? 1'b0 : (f_both >= 0) ? (f_both != 0) : bit'($urandom_range(0, 1));
    if (both) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = e.rdata;
    end
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (!e.we && !both) begin
      rd = (f_rdly >= 0) ? f_rdly : int'($urandom_range(0, 4));
      for (int i = 0; i < rd; i++) begin
        @(negedge clk);
        chk("ready_low_wait", 64'(in_ready_o), 64'd0);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = e.rdata;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem && rst && mem_req_o) serve();
    end
  end

  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst && wb_valid_o) begin
        if (wb_q.size() == 0) chk("unexpected_wb", 64'd1, 64'd0);
        else begin
          e = wb_q.pop_front();
          chk("wb_rd_wr_en", 64'(wb_rd_wr_en_o), 64'(e.en));
          chk("wb_rd_idx", 64'(wb_rd_idx_o), 64'(e.idx));
          chk("wb_err", 64'(err_o), 64'(e.err));
          if (e.chk_data) chk("wb_data", wb_data_o, e.data);
        end
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", 64'(wb_q.size() + mem_q.size()), 64'd0);
    f_gdly = -1; f_both = -1; f_rdly = -1; f_stray = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [6:0]  info;
    logic [63:0] a;
    int          n;
    #12;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    chk("rst_wmask", 64'(mem_wmask_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Non-LS pass-through, one-cycle latency.
    issue(7'b0000000, 64'h1234, 64'd0, 1'b1, 5'd5, 64'd0, 1'b1);
    chk("nonls_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("nonls_no_req", 64'(mem_req_o), 64'd0);
    chk("nonls_data", wb_data_o, 64'h1234);
    drain();

    // lb / lbu with gnt and rvalid together.
    f_gdly = 0; f_both = 1;
    issue(7'b0001001, 64'h8000_0003, 64'd0, 1'b1, 5'd7, 64'h0000_0000_8000_0000, 1'b1);
    drain();
    f_gdly = 0; f_both = 1;
    issue(7'b0001101, 64'h8000_0003, 64'd0, 1'b1, 5'd7, 64'h0000_0000_8000_0000, 1'b1);
    drain();

    // sh at byte 6, grant after three waiting cycles.
    f_gdly = 3;
    issue(7'b0010010, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 1'b1, 5'd3, 64'd0, 1'b1);
    drain();

    // Misaligned lw.
    issue(7'b0100001, 64'h8000_0002, 64'd0, 1'b1, 5'd9, 64'd0, 1'b1);
    chk("mis_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("mis_err", 64'(err_o), 64'd1);
    chk("mis_no_req", 64'(mem_req_o), 64'd0);
    drain();

    // ld with late rvalid and stray rvalid while still in REQ.
    f_gdly = 2; f_both = 0; f_rdly = 5; f_stray = 1;
    issue(7'b1000001, 64'h8000_0010, 64'd0, 1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 1'b1);
    drain();

    // Reset during REQ and during WAIT drops the access.
    auto_mem = 1'b0;
    issue(7'b1000001, 64'h100, 64'd0, 1'b1, 5'd4, 64'd0, 1'b0);
    chk("rst_req_pre", 64'(mem_req_o), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstreq_mem_req", 64'(mem_req_o), 64'd0);
    chk("rstreq_in_ready", 64'(in_ready_o), 64'd1);
    chk("rstreq_wb_valid", 64'(wb_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(7'b1000001, 64'h200, 64'd0, 1'b1, 5'd4, 64'd0, 1'b0);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("wait_ready_low", 64'(in_ready_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstwait_mem_req", 64'(mem_req_o), 64'd0);
    chk("rstwait_in_ready", 64'(in_ready_o), 64'd1);
    chk("rstwait_wb_valid", 64'(wb_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    auto_mem = 1'b1;
    f_gdly = 1; f_both = 1;
    issue(7'b0100001, 64'h300, 64'd0, 1'b1, 5'd6, 64'hFFFF_FFFF_7654_3210, 1'b1);
    drain();

    // Randomised mix of non-LS, loads, stores and load+store requests.
    for (int k = 0; k < 300; k++) begin
      n = int'($urandom_range(0, 4));
      info[6:3] = (n < 4) ? 4'(1 << n) : 4'd0;
      info[2]   = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       info[1:0] = 2'b00;
        1:       info[1:0] = 2'b01;
        2:       info[1:0] = 2'b10;
        default: info[1:0] = 2'b11;
      endcase
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << ((n < 4) ? n : 0)) - 1);
      issue(info, a, {$urandom, $urandom}, 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), {$urandom, $urandom}, 1'b1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
